// File: rtl/axi_stream_pkg.sv
// Shared AXI-Stream definitions for the header insert/remove stages.
//   AXIS_DATA_WD : default data bus width in bits
//   axis_state_e : packet FSM state encoding shared by both stages
package axi_stream_pkg;

  localparam int AXIS_DATA_WD = 32;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FIRST = 2'd1,
    ST_STREAM     = 2'd2,
    ST_FLUSH      = 2'd3
  } axis_state_e;

endpackage

// File: rtl/axis_realign_mux.sv
// Combinational byte realignment for header removal.
// Byte lane DATA_BYTE_WD-1 (MSB) is the first byte of a beat.
//   res_i     : residual bytes, MSB-aligned
//   data_i    : incoming beat data
//   keep_i    : incoming keep (MSB-contiguous)
//   last_i    : incoming beat is the last of the packet
//   first_i   : first beat of packet (output, if any, is the empty beat)
//   flush_i   : emit the residual alone (trailing beat)
//   s_i       : bytes to strip
//   rem_i     : residual byte count used during flush
//   data_o    : output data, lanes with keep 0 zeroed
//   keep_o    : output keep
//   res_nxt_o : residual for the next beat
//   extra_o   : last beat leaves bytes that need a trailing flush beat
//   rem_o     : byte count left for the flush beat
module axis_realign_mux #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
  input  logic [DATA_WD-1:0]      res_i,
  input  logic [DATA_WD-1:0]      data_i,
  input  logic [DATA_BYTE_WD-1:0] keep_i,
  input  logic                    last_i,
  input  logic                    first_i,
  input  logic                    flush_i,
  input  logic [BYTE_CNT_WD-1:0]  s_i,
  input  logic [CNT_WD-1:0]       rem_i,
  output logic [DATA_WD-1:0]      data_o,
  output logic [DATA_BYTE_WD-1:0] keep_o,
  output logic [DATA_WD-1:0]      res_nxt_o,
  output logic                    extra_o,
  output logic [CNT_WD-1:0]       rem_o
);

  int                 n, s, kcnt;
  logic [DATA_WD-1:0] msk, cat, sel;

  always_comb begin
    n    = 0;
    s    = int'(s_i);
    kcnt = DATA_BYTE_WD;
    msk  = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      n = n + int'(keep_i[i]);
      if (keep_i[i]) msk[i*8 +: 8] = data_i[i*8 +: 8];
    end
    // Residual occupies the top DATA_BYTE_WD-s lanes; the beat's first s
    // bytes slide into the low lanes. With s=0 the shift clears the beat.
    cat       = res_i | (msk >> ((DATA_BYTE_WD - s) * 8));
    res_nxt_o = msk << (s * 8);
    extra_o   = last_i && (n > s);
    rem_o     = extra_o ? CNT_WD'(n - s) : '0;

    sel = cat;
    if (flush_i) begin
      sel  = res_i;
      kcnt = int'(rem_i);
    end else if (first_i) begin
      kcnt = 0;
    end else if (last_i && (n <= s)) begin
      kcnt = DATA_BYTE_WD - s + n;
    end

    data_o = '0;
    keep_o = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      keep_o[i] = (i >= DATA_BYTE_WD - kcnt);
      if (keep_o[i]) data_o[i*8 +: 8] = sel[i*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_stream_remove_header.sv
// Strips the first s bytes of each AXI-Stream packet and realigns the rest.
//   clk, rst_n            : clock, async active-low reset
//   valid_remove/byte_remove_cnt/ready_remove : per-packet strip command
//   valid_in/data_in/keep_in/last_in/ready_in : upstream stream
//   valid_out/data_out/keep_out/last_out/ready_out : realigned stream (registered)
module axi_stream_remove_header
  import axi_stream_pkg::*;
#(
  parameter int DATA_WD      = AXIS_DATA_WD,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_remove,
  input  logic [BYTE_CNT_WD-1:0]  byte_remove_cnt,
  output logic                    ready_remove
);

  localparam int CNT_WD = $clog2(DATA_BYTE_WD + 1);

  axis_state_e               state_q, state_d;
  logic [DATA_WD-1:0]        res_q, res_d;
  logic [BYTE_CNT_WD-1:0]    s_q, s_d;
  logic [CNT_WD-1:0]         rem_q, rem_d;
  logic                      vld_d, last_d;
  logic [DATA_WD-1:0]        data_d;
  logic [DATA_BYTE_WD-1:0]   keep_d;

  logic                      can_load, hs, load, first, flush;
  logic [DATA_WD-1:0]        mx_data, mx_res;
  logic [DATA_BYTE_WD-1:0]   mx_keep;
  logic                      mx_extra;
  logic [CNT_WD-1:0]         mx_rem;

  assign first = (state_q == ST_WAIT_FIRST);
  assign flush = (state_q == ST_FLUSH);

  axis_realign_mux #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD),
    .CNT_WD       (CNT_WD)
  ) u_mux (
    .res_i     (res_q),
    .data_i    (data_in),
    .keep_i    (keep_in),
    .last_i    (last_in),
    .first_i   (first),
    .flush_i   (flush),
    .s_i       (s_q),
    .rem_i     (rem_q),
    .data_o    (mx_data),
    .keep_o    (mx_keep),
    .res_nxt_o (mx_res),
    .extra_o   (mx_extra),
    .rem_o     (mx_rem)
  );

  always_comb begin
    state_d      = state_q;
    res_d        = res_q;
    s_d          = s_q;
    rem_d        = rem_q;
    ready_remove = 1'b0;
    ready_in     = 1'b0;
    load         = 1'b0;
    can_load     = !valid_out || ready_out;
    hs           = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_remove = 1'b1;
        if (valid_remove) begin
          s_d     = byte_remove_cnt;
          state_d = ST_WAIT_FIRST;
        end
      end
      ST_WAIT_FIRST, ST_STREAM: begin
        ready_in = can_load;
        hs       = valid_in && ready_in;
        if (hs) begin
          res_d = mx_res;
          // First beat only produces output when the packet ends short
          // (the empty beat); later beats always produce one.
          load  = !first || (last_in && !mx_extra);
          if (!last_in)      state_d = ST_STREAM;
          else if (mx_extra) begin
            rem_d   = mx_rem;
            state_d = ST_FLUSH;
          end else           state_d = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (can_load) begin
          load    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    vld_d  = valid_out && !ready_out;
    data_d = data_out;
    keep_d = keep_out;
    last_d = last_out;
    if (load) begin
      vld_d  = 1'b1;
      data_d = mx_data;
      keep_d = mx_keep;
      last_d = flush || (last_in && !mx_extra);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      res_q     <= '0;
      s_q       <= '0;
      rem_q     <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      keep_out  <= '0;
      last_out  <= 1'b0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      s_q       <= s_d;
      rem_q     <= rem_d;
      valid_out <= vld_d;
      data_out  <= data_d;
      keep_out  <= keep_d;
      last_out  <= last_d;
    end
  end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Directed bench for axi_stream_remove_header (DATA_WD=32).
module tb_axi_stream_remove_header;

  logic        clk, rst_n;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        valid_remove, ready_remove;
  logic [1:0]  byte_remove_cnt;

  int n_chk = 0;
  int n_fail = 0;
  logic [36:0] exp_q[$];

  axi_stream_remove_header dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
    .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
    .ready_out(ready_out),
    .valid_remove(valid_remove), .byte_remove_cnt(byte_remove_cnt),
    .ready_remove(ready_remove)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output scoreboard: every accepted output beat must match the next expected one.
  always @(negedge clk) begin
    if (rst_n && valid_out && ready_out) begin
      if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
      else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        chk("out_data", data_out, e[36:5]);
        chk("out_keep", keep_out, e[4:1]);
        chk("out_last", last_out, e[0]);
      end
    end
  end

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back({d, k, l});
  endtask

  task automatic send_cmd(input logic [1:0] s);
    int t = 0;
    valid_remove = 1'b1; byte_remove_cnt = s;
    @(negedge clk);
    while (!ready_remove && t < 100) begin @(negedge clk); t++; end
    if (!ready_remove) chk("cmd_timeout", 1, 0);
    @(posedge clk); #1;
    valid_remove = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int t = 0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    @(negedge clk);
    while (!ready_in && t < 100) begin @(negedge clk); t++; end
    if (!ready_in) chk("beat_timeout", 1, 0);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge clk); t++; end
    chk(tag, exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ready_out = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_remove = 1'b0; byte_remove_cnt = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_keep_out", keep_out, 0);
    chk("rst_ready_in", ready_in, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready_remove", ready_remove, 1);
    @(posedge clk); #1;

    // s=1, two full beats: one realigned beat plus a flush beat
    expect_beat(32'hA1A2A3B0, 4'hF, 1'b0);
    expect_beat(32'hB1B2B3_00, 4'hE, 1'b1);
    send_cmd(2'd1);
    send_beat(32'hA0A1A2A3, 4'hF, 1'b0);
    chk("wait_first_no_out", valid_out, 0);
    send_beat(32'hB0B1B2B3, 4'hF, 1'b1);
    chk("flush_ready_in", ready_in, 0);
    drain("drain_s1");

    // s=2, short last beat folds into a single output beat, no flush
    expect_beat(32'h33445566, 4'hF, 1'b1);
    send_cmd(2'd2);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h5566ABCD, 4'hC, 1'b1);
    chk("s2_no_flush_idle", ready_remove, 1);
    drain("drain_s2");

    // s=0 pass-through with one-beat delay
    expect_beat(32'hC0C1C2C3, 4'hF, 1'b0);
    expect_beat(32'hD0D1D2D3, 4'hF, 1'b0);
    expect_beat(32'hE0000000, 4'h8, 1'b1);
    send_cmd(2'd0);
    send_beat(32'hC0C1C2C3, 4'hF, 1'b0);
    #3 chk("s0_first_no_out", valid_out, 0);
    send_beat(32'hD0D1D2D3, 4'hF, 1'b0);
    #3 chk("s0_out_after_2nd", valid_out, 1);
    send_beat(32'hE0000000, 4'h8, 1'b1);
    drain("drain_s0");

    // s=1 with a 3-cycle downstream stall mid-packet
    expect_beat(32'h02030405, 4'hF, 1'b0);
    expect_beat(32'h06070809, 4'hF, 1'b0);
    expect_beat(32'h0A0B0C0D, 4'hF, 1'b0);
    expect_beat(32'h0E000000, 4'h8, 1'b1);
    fork
      begin
        send_cmd(2'd1);
        send_beat(32'h01020304, 4'hF, 1'b0);
        send_beat(32'h05060708, 4'hF, 1'b0);
        send_beat(32'h090A0B0C, 4'hF, 1'b0);
        send_beat(32'h0D0EFFFF, 4'hC, 1'b1);
      end
      begin
        int t = 0;
        logic [31:0] sd;
        logic [3:0]  sk;
        while (!valid_out && t < 100) begin @(negedge clk); t++; end
        chk("stall_saw_valid", valid_out, 1);
        @(posedge clk); #1;
        ready_out = 1'b0;
        @(negedge clk);
        sd = data_out; sk = keep_out;
        chk("stall_ready_in", ready_in, 0);
        repeat (2) begin
          @(negedge clk);
          chk("stall_valid", valid_out, 1);
          chk("stall_data", data_out, sd);
          chk("stall_keep", keep_out, sk);
          chk("stall_ready_in", ready_in, 0);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
      end
    join
    drain("drain_stall");

    // s=3, single 1-byte packet: empty last beat
    expect_beat(32'h00000000, 4'h0, 1'b1);
    send_cmd(2'd3);
    send_beat(32'h99AABBCC, 4'h8, 1'b1);
    drain("drain_s3");

    // reset in the middle of a packet
    ready_out = 1'b0;
    send_cmd(2'd2);
    send_beat(32'h11223344, 4'hF, 1'b0);
    send_beat(32'h55667788, 4'hF, 1'b0);
    #2 chk("pre_rst_valid", valid_out, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid_out", valid_out, 0);
    chk("midrst_data_out", data_out, 0);
    chk("midrst_keep_out", keep_out, 0);
    chk("midrst_last_out", last_out, 0);
    chk("midrst_ready_in", ready_in, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; ready_out = 1'b1;
    @(negedge clk);
    chk("post_rst_ready_remove", ready_remove, 1);
    @(posedge clk); #1;
    expect_beat(32'h0C0D0E0F, 4'hF, 1'b1);
    send_cmd(2'd2);
    send_beat(32'h0A0B0C0D, 4'hF, 1'b0);
    send_beat(32'h0E0F1234, 4'hC, 1'b1);
    drain("drain_post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_stream_remove_header.md
AXI_STREAM_REMOVE_HEADER -- requirements
Module: axi_stream_remove_header

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, data bus width in bits.
REQ-002 SHALL have parameter DATA_BYTE_WD, default DATA_WD/8, byte lanes per beat.
REQ-003 SHALL have parameter BYTE_CNT_WD, default $clog2(DATA_BYTE_WD), width of the strip count.
REQ-004 SHALL have clk  input  1  clock, all logic on rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have valid_in / data_in / keep_in / last_in  input  1 / DATA_WD / DATA_BYTE_WD / 1  upstream AXI-Stream beat.
REQ-007 SHALL have ready_in  output  1  upstream beat accepted when valid_in && ready_in.
REQ-008 SHALL have valid_out / data_out / keep_out / last_out  output  1 / DATA_WD / DATA_BYTE_WD / 1  realigned stream.
REQ-009 SHALL have ready_out  input  1  downstream acceptance.
REQ-010 SHALL have valid_remove / byte_remove_cnt  input  1 / BYTE_CNT_WD  per-packet count s of leading bytes to strip.
REQ-011 SHALL have ready_remove  output  1  strip command accepted when valid_remove && ready_remove.

Function
REQ-012 SHALL treat byte lane DATA_BYTE_WD-1 (data MSB) as the first byte of a beat, with keep_in all-ones on non-last beats and MSB-contiguous on last beats (n valid bytes, n >= 1).
REQ-013 SHALL run FSM IDLE -> WAIT_FIRST (command accepted, s latched) -> STREAM (first beat accepted) -> FLUSH (if needed) -> IDLE.
REQ-014 SHALL assert ready_remove only in IDLE; ready_in SHALL be low in IDLE and FLUSH.
REQ-015 SHALL, in WAIT_FIRST and STREAM, assert ready_in = !valid_out || ready_out.
REQ-016 SHALL store the lower DATA_BYTE_WD-s bytes of each accepted beat in a residual register; the first beat produces no output.
REQ-017 SHALL, on each later non-last beat, emit {residual, upper s bytes of beat} with keep_out all-ones, last_out=0.
REQ-018 SHALL, on last beat with n <= s, emit {residual, upper n bytes, zero fill} with keep_out covering DATA_BYTE_WD-s+n MSB lanes, last_out=1, return to IDLE.
REQ-019 SHALL, on last beat with n > s, emit full-keep beat as REQ-017, enter FLUSH, then emit lower n-s bytes MSB-aligned with keep of n-s lanes, last_out=1, return to IDLE.
REQ-020 SHALL, for a single-beat packet with n <= s, emit one beat with keep_out=0, data_out=0, last_out=1.
REQ-021 SHALL register all outputs; output beat appears the cycle after the triggering input handshake; sustained throughput one beat per cycle outside FLUSH.
REQ-022 SHALL hold data_out/keep_out/last_out/valid_out stable while valid_out && !ready_out.
REQ-023 SHALL zero data_out lanes whose keep_out bit is 0.
REQ-024 SHALL treat s = 0 as pass-through with one-beat delay plus FLUSH on every last beat.

Reset
REQ-025 SHALL, on rst_n low, force valid_out, last_out, data_out, keep_out, residual to 0, ready_in to 0, state to IDLE, regardless of packet in flight.
REQ-026 SHALL assert ready_remove in the first cycle after rst_n deasserts.

Structure
REQ-027 SHALL take DATA_WD default and FSM state encodings from the shared axi_stream package used by the header-insert stage.
REQ-028 SHALL place byte realignment (residual/beat concatenation, keep generation) in combinational sub-module axis_realign_mux; FSM and registers in top.

Verification (DATA_WD=32, bytes listed MSB first)
REQ-029 SHALL check s=1, beats A0A1A2A3, B0B1B2B3 keep 1111 last -> A1A2A3B0 keep 1111, then B1B2B3_00 keep 1110 last.
REQ-030 SHALL check s=2, beats 11223344, 5566_0000 keep 1100 last -> single beat 33445566 keep 1111 last, no FLUSH.
REQ-031 SHALL check s=0, three full beats (last keep 1000) -> identical three beats out, first valid_out 1 cycle after second input handshake.
REQ-032 SHALL check ready_out low 3 cycles mid-packet -> outputs stable, ready_in low, no byte lost or duplicated.
REQ-033 SHALL check s=3, single beat keep 1000 last -> one beat keep 0000, data 0, last_out 1.
REQ-034 SHALL check rst_n pulsed during STREAM -> all outputs 0 same cycle, next packet processed correctly after release.
